// File: rtl/src_b_stage.sv
// rtl/src_b_stage.sv - B-operand source select/extend stage with a 2-entry output skid FIFO
module src_b_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 16,
   parameter int INC_CONST  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            sel,
   input  logic [DATA_WIDTH-1:0] reg_b,
   input  logic [IMM_WIDTH-1:0]  imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] INC_W = DATA_WIDTH'(INC_CONST);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
   logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
   logic                  head_err_q, head_err_d;
   logic                  tail_err_q, tail_err_d;

   logic [DATA_WIDTH-1:0] imm_sext;
   logic [DATA_WIDTH-1:0] imm_zext;
   logic [DATA_WIDTH-1:0] new_data;
   logic                  new_err;
   logic                  push;
   logic                  pop;

   assign imm_sext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   assign imm_zext = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};

   always_comb begin
      new_data = '1;
      new_err  = 1'b0;
      case (sel)
         3'b000:  new_data = reg_b;
         3'b001:  new_data = INC_W;
         3'b010:  new_data = imm_sext;
         3'b011:  new_data = imm_zext;
         3'b100:  new_data = {imm_sext[DATA_WIDTH-3:0], 2'b00};
         default: begin
            new_data = '1;
            new_err  = 1'b1;
         end
      endcase
   end

   // Handshake flags depend on state only, so no input reaches out_* combinationally.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_data_q;
   assign out_err   = head_err_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_err_d  = head_err_q;
      tail_data_d = tail_data_q;
      tail_err_d  = tail_err_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               head_data_d = new_data;
               head_err_d  = new_err;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_data_d = new_data;
               head_err_d  = new_err;
            end else if (push) begin
               tail_data_d = new_data;
               tail_err_d  = new_err;
               state_d     = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_data_d = tail_data_q;
               head_err_d  = tail_err_q;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_err_q  <= 1'b0;
         tail_data_q <= '0;
         tail_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_err_q  <= head_err_d;
         tail_data_q <= tail_data_d;
         tail_err_q  <= tail_err_d;
      end
   end

endmodule

// File: tb/tb_src_b_stage.sv
// tb/tb_src_b_stage.sv - scoreboard bench for src_b_stage
module tb_src_b_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  sel = 3'd0;
   logic [31:0] reg_b = 32'd0;
   logic [15:0] imm = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_err;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   src_b_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .reg_b     (reg_b),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Reference: {err, data} from the operand rules using plain integer arithmetic.
   function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] rb,
                                         input logic [15:0] im);
      longint sv;
      sv = longint'(im);
      if (im >= 16'h8000) sv = sv - 65536;
      case (s)
         3'd0:    return {1'b0, rb};
         3'd1:    return {1'b0, 32'd1};
         3'd2:    return {1'b0, 32'(sv)};
         3'd3:    return {1'b0, 32'(longint'(im))};
         3'd4:    return {1'b0, 32'(sv * 4)};
         default: return {1'b1, 32'hFFFF_FFFF};
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) exp_q.push_back(model(sel, reg_b, imm));
   end

   logic        hold_v = 1'b0;
   logic [32:0] hold_val = '0;
   logic [32:0] popped;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) chk("hold_stable", 64'({out_valid, out_err, out_data}), 64'({1'b1, hold_val}));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
               popped = exp_q.pop_front();
               chk("scoreboard", 64'({out_err, out_data}), 64'(popped));
            end
         end
         hold_v   = out_valid && !out_ready;
         hold_val = {out_err, out_data};
      end
   end

   logic [2:0]  t_sel [7] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd6, 3'd0};
   logic [31:0] t_rb  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'h12345678};
   logic [31:0] t_exp [7] = '{32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h1,
                              32'hDEADBEEF, 32'hFFFFFFFF, 32'h12345678};
   logic        t_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 64'({out_valid, in_ready, out_err, out_data}), 64'({1'b0, 1'b1, 1'b0, 32'd0}));
      rst = 1'b0;

      out_ready = 1'b1;
      imm = 16'h8001;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         sel      = t_sel[i];
         reg_b    = t_rb[i];
         step();
         chk("dir_valid", 64'(out_valid), 64'(1));
         chk("dir_data", 64'(out_data), 64'(t_exp[i]));
         chk("dir_err", 64'(out_err), 64'(t_err[i]));
      end
      in_valid = 1'b0;
      step();
      chk("dir_empty", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

      out_ready = 1'b0;
      sel = 3'd0;
      in_valid = 1'b1; reg_b = 32'd5; step();
      reg_b = 32'd7; step();
      chk("bp_full", 64'({out_valid, in_ready, out_data}), 64'({1'b1, 1'b0, 32'd5}));
      reg_b = 32'd9; step();
      chk("bp_ignore", 64'({out_valid, in_ready, out_data}), 64'({1'b1, 1'b0, 32'd5}));
      in_valid = 1'b0; out_ready = 1'b1; step();
      chk("bp_second", 64'({out_valid, in_ready, out_data}), 64'({1'b1, 1'b1, 32'd7}));
      step();
      chk("bp_drained", 64'(out_valid), 64'(0));

      out_ready = 1'b0;
      in_valid = 1'b1; reg_b = 32'd3; step();
      reg_b = 32'd4; out_ready = 1'b1; step();
      chk("pushpop", 64'({out_valid, in_ready, out_data}), 64'({1'b1, 1'b1, 32'd4}));
      in_valid = 1'b0; step();
      chk("pushpop_drain", 64'(out_valid), 64'(0));

      out_ready = 1'b0;
      in_valid = 1'b1; reg_b = 32'd5; step();
      reg_b = 32'd6; step();
      in_valid = 1'b0;
      chk("rst_pre_full", 64'(in_ready), 64'(0));
      #2 rst = 1'b1;
      #1;
      chk("rst_async", 64'({out_valid, in_ready, out_err, out_data}), 64'({1'b0, 1'b1, 1'b0, 32'd0}));
      exp_q.delete();
      step();
      rst = 1'b0;
      in_valid = 1'b1; sel = 3'd0; reg_b = 32'h77;
      step();
      chk("rst_first_push", 64'({out_valid, out_data}), 64'({1'b1, 32'h77}));
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("rst_no_stale", 64'(out_valid), 64'(0));

      for (int i = 0; i < 600; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         sel       = 3'($urandom_range(0, 7));
         reg_b     = $urandom;
         imm       = 16'($urandom);
         step();
         chk("occupancy", 64'({out_valid, in_ready}),
             64'({exp_q.size() > 0, exp_q.size() < 2}));
      end

      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5 && out_valid; i++) step();
      chk("final_drain", 64'(out_valid), 64'(0));
      chk("final_queue", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
